// File: rtl/wb_load_pkg.sv
// Shared encodings for the writeback load-return unit: access size, merge mode and FSM state.
package wb_load_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      MG_NONE = 2'd0,
      MG_LWL  = 2'd1,
      MG_LWR  = 2'd2
   } merge_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/wb_load_unit_if.sv
// MEM-side request, RAM read-return and regfile-side writeback signals of the load unit.
interface wb_load_unit_if #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
);
   // req_* and wb_* are valid/ready handshakes: a transfer occurs on a rising edge with valid and
   // ready both high, and the sender holds valid and payload stable until then. ram_rvalid is a
   // one-cycle data pulse with no back-pressure.
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic [1:0]            req_size;
   logic                  req_sign;
   logic [1:0]            req_merge;
   logic [DATA_W-1:0]     req_old;
   logic [REG_ADDR_W-1:0] req_reg_addr;
   logic [ADDR_W-1:0]     req_pc;

   logic                  ram_rvalid;
   logic [DATA_W-1:0]     ram_rdata;

   logic                  wb_valid;
   logic                  wb_ready;
   logic [DATA_W-1:0]     wb_data;
   logic [REG_ADDR_W-1:0] wb_reg_addr;
   logic [ADDR_W-1:0]     wb_pc;
   logic                  wb_exc;

   modport master (
      output req_valid, req_addr, req_size, req_sign, req_merge, req_old, req_reg_addr, req_pc,
      output ram_rvalid, ram_rdata, wb_ready,
      input  req_ready, wb_valid, wb_data, wb_reg_addr, wb_pc, wb_exc
   );

   modport slave (
      input  req_valid, req_addr, req_size, req_sign, req_merge, req_old, req_reg_addr, req_pc,
      input  ram_rvalid, ram_rdata, wb_ready,
      output req_ready, wb_valid, wb_data, wb_reg_addr, wb_pc, wb_exc
   );
endinterface

// File: rtl/load_formatter.sv
// Combinational lane extract/extend, LWL/LWR merge and misalignment detect for one load.
module load_formatter
   import wb_load_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  size_e             size,
   input  logic              sign,
   input  merge_e            merge,
   input  logic [DATA_W-1:0] old,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] data,
   output logic              misaligned
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   logic [OFF_W-1:0]  off;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lane_mask;
   logic [DATA_W-1:0] extended;
   logic              sbit;
   logic [31:0]       word_lane;
   logic [31:0]       lwl;
   logic [31:0]       lwr;
   logic [31:0]       merged;
   logic [1:0]        k;
   logic [4:0]        lwl_sh;
   logic [4:0]        lwr_sh;
   logic              merge_on;
   logic              low_bad;
   logic              too_wide;
   logic              unused_fmt;

   assign off     = addr[OFF_W-1:0];
   assign k       = addr[1:0];
   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      lane_mask = '1;
      sbit      = shifted[DATA_W-1];
      low_bad   = (addr[2:0] != 3'd0);
      case (size)
         SZ_BYTE: begin lane_mask = DATA_W'(8'hFF);        sbit = shifted[7];  low_bad = 1'b0;               end
         SZ_HALF: begin lane_mask = DATA_W'(16'hFFFF);     sbit = shifted[15]; low_bad = addr[0];            end
         SZ_WORD: begin lane_mask = DATA_W'(32'hFFFF_FFFF); sbit = shifted[31]; low_bad = (addr[1:0] != 2'd0); end
         default: ;
      endcase
   end

   assign extended = (shifted & lane_mask) | ((sign & sbit) ? ~lane_mask : '0);

   // Unaligned-word merges always work on the 32-bit word lane addressed by the load.
   generate
      if (DATA_W > 32) begin : g_wide
         assign word_lane = addr[2] ? rdata[DATA_W-1 -: 32] : rdata[31:0];
      end else begin : g_narrow
         assign word_lane = rdata[31:0];
      end
   endgenerate

   assign lwl_sh   = {~k, 3'b000};
   assign lwr_sh   = {k, 3'b000};
   assign lwl      = (word_lane << lwl_sh) | (old[31:0] & ~(32'hFFFF_FFFF << lwl_sh));
   assign lwr      = (word_lane >> lwr_sh) | (old[31:0] & ~(32'hFFFF_FFFF >> lwr_sh));
   assign merge_on = (size == SZ_WORD) && ((merge == MG_LWL) || (merge == MG_LWR));
   assign merged   = (merge == MG_LWL) ? lwl : lwr;

   // Merged words are sign-extended on wide datapaths, as a 32-bit register result would be.
   assign data       = merge_on ? DATA_W'($signed(merged)) : extended;
   assign too_wide   = (int'(size) > OFF_W);
   assign misaligned = !merge_on && (low_bad || too_wide);

   assign unused_fmt = ^{addr, old};
endmodule

// File: rtl/wb_load_unit.sv
// Load-return unit: accepts a MEM load, waits for the RAM response, formats it and holds the
// result for the regfile; misaligned loads return the faulting address with wb_exc set.
module wb_load_unit
   import wb_load_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   wb_load_unit_if.slave bus,
   output state_e        dbg_state
);
   state_e                state;
   logic [ADDR_W-1:0]     r_addr;
   size_e                 r_size;
   logic                  r_sign;
   merge_e                r_merge;
   logic [DATA_W-1:0]     r_old;
   logic [REG_ADDR_W-1:0] r_reg_addr;
   logic [ADDR_W-1:0]     r_pc;
   logic                  wb_valid_q;
   logic                  wb_exc_q;
   logic [DATA_W-1:0]     wb_data_q;

   logic                  accept;
   logic                  in_wait;
   logic [ADDR_W-1:0]     f_addr;
   size_e                 f_size;
   logic                  f_sign;
   merge_e                f_merge;
   logic [DATA_W-1:0]     f_old;
   logic [DATA_W-1:0]     f_data;
   logic                  f_misaligned;

   assign bus.req_ready = rst & ~flush & ((state == IDLE) | ((state == DONE) & bus.wb_ready));
   assign accept        = bus.req_valid & bus.req_ready;

   // One formatter serves both paths: live request fields for the alignment check at accept,
   // latched fields while waiting for the RAM response.
   assign in_wait = (state == WAIT);
   assign f_addr  = in_wait ? r_addr  : bus.req_addr;
   assign f_size  = in_wait ? r_size  : size_e'(bus.req_size);
   assign f_sign  = in_wait ? r_sign  : bus.req_sign;
   assign f_merge = in_wait ? r_merge : merge_e'(bus.req_merge);
   assign f_old   = in_wait ? r_old   : bus.req_old;

   load_formatter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fmt (
      .addr       (f_addr),
      .size       (f_size),
      .sign       (f_sign),
      .merge      (f_merge),
      .old        (f_old),
      .rdata      (bus.ram_rdata),
      .data       (f_data),
      .misaligned (f_misaligned)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         r_addr     <= '0;
         r_size     <= SZ_BYTE;
         r_sign     <= 1'b0;
         r_merge    <= MG_NONE;
         r_old      <= '0;
         r_reg_addr <= '0;
         r_pc       <= '0;
         wb_valid_q <= 1'b0;
         wb_exc_q   <= 1'b0;
         wb_data_q  <= '0;
      end else if (flush) begin
         case (state)
            WAIT:    state <= bus.ram_rvalid ? IDLE : DRAIN;
            DRAIN:   if (bus.ram_rvalid) state <= IDLE;
            DONE: begin
               state      <= IDLE;
               wb_valid_q <= 1'b0;
               wb_exc_q   <= 1'b0;
            end
            default: ;
         endcase
      end else begin
         case (state)
            IDLE, DONE: begin
               if ((state == DONE) && bus.wb_ready) begin
                  state      <= IDLE;
                  wb_valid_q <= 1'b0;
                  wb_exc_q   <= 1'b0;
               end
               if (accept) begin
                  r_addr     <= bus.req_addr;
                  r_size     <= size_e'(bus.req_size);
                  r_sign     <= bus.req_sign;
                  r_merge    <= merge_e'(bus.req_merge);
                  r_old      <= bus.req_old;
                  r_reg_addr <= bus.req_reg_addr;
                  r_pc       <= bus.req_pc;
                  if (f_misaligned) begin
                     state      <= DONE;
                     wb_valid_q <= 1'b1;
                     wb_exc_q   <= 1'b1;
                     wb_data_q  <= DATA_W'(bus.req_addr);
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (bus.ram_rvalid) begin
                  state      <= DONE;
                  wb_valid_q <= 1'b1;
                  wb_exc_q   <= 1'b0;
                  wb_data_q  <= f_data;
               end
            end
            DRAIN: if (bus.ram_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_exc      = wb_exc_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_reg_addr = r_reg_addr;
   assign bus.wb_pc       = r_pc;
   assign dbg_state       = state;
endmodule

// File: tb/tb_wb_load_unit.sv
// Bench for wb_load_unit: a 32-bit and a 64-bit instance share stimulus, one selected at a time.
module tb_wb_load_unit;
   import wb_load_pkg::*;

   localparam int EW = 102;  // {exc, reg_addr, pc, data64}

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   logic sel64 = 1'b0;

   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_sign = 1'b0;
   logic [1:0]  req_merge = '0;
   logic [63:0] req_old = '0;
   logic [4:0]  req_reg = '0;
   logic [31:0] req_pc = '0;
   logic        ram_rvalid = 1'b0;
   logic [63:0] ram_rdata = '0;
   logic        wb_ready = 1'b0;

   logic [EW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_load_unit_if #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) if32 ();
   wb_load_unit_if #(.DATA_W(64), .ADDR_W(32), .REG_ADDR_W(5)) if64 ();

   state_e st32, st64;

   wb_load_unit #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) u32 (
      .clk(clk), .rst(rst), .flush(flush), .bus(if32.slave), .dbg_state(st32));
   wb_load_unit #(.DATA_W(64), .ADDR_W(32), .REG_ADDR_W(5)) u64 (
      .clk(clk), .rst(rst), .flush(flush), .bus(if64.slave), .dbg_state(st64));

   assign if32.req_valid    = req_valid & ~sel64;
   assign if32.req_addr     = req_addr;
   assign if32.req_size     = req_size;
   assign if32.req_sign     = req_sign;
   assign if32.req_merge    = req_merge;
   assign if32.req_old      = req_old[31:0];
   assign if32.req_reg_addr = req_reg;
   assign if32.req_pc       = req_pc;
   assign if32.ram_rvalid   = ram_rvalid & ~sel64;
   assign if32.ram_rdata    = ram_rdata[31:0];
   assign if32.wb_ready     = wb_ready & ~sel64;

   assign if64.req_valid    = req_valid & sel64;
   assign if64.req_addr     = req_addr;
   assign if64.req_size     = req_size;
   assign if64.req_sign     = req_sign;
   assign if64.req_merge    = req_merge;
   assign if64.req_old      = req_old;
   assign if64.req_reg_addr = req_reg;
   assign if64.req_pc       = req_pc;
   assign if64.ram_rvalid   = ram_rvalid & sel64;
   assign if64.ram_rdata    = ram_rdata;
   assign if64.wb_ready     = wb_ready & sel64;

   logic        cur_req_ready, cur_wb_valid, cur_exc;
   logic [63:0] cur_data;
   logic [4:0]  cur_reg;
   logic [31:0] cur_pc;
   state_e      cur_state;

   assign cur_req_ready = sel64 ? if64.req_ready   : if32.req_ready;
   assign cur_wb_valid  = sel64 ? if64.wb_valid    : if32.wb_valid;
   assign cur_exc       = sel64 ? if64.wb_exc      : if32.wb_exc;
   assign cur_data      = sel64 ? if64.wb_data     : {32'h0, if32.wb_data};
   assign cur_reg       = sel64 ? if64.wb_reg_addr : if32.wb_reg_addr;
   assign cur_pc        = sel64 ? if64.wb_pc       : if32.wb_pc;
   assign cur_state     = sel64 ? st64             : st32;

   initial begin
      #400000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1, "bench timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                          input logic [1:0] mg, input logic [63:0] old, input logic [4:0] ra,
                          input logic push, input logic ex, input logic [63:0] d);
      req_valid = 1'b1;
      req_addr  = a;
      req_size  = sz;
      req_sign  = sg;
      req_merge = mg;
      req_old   = old;
      req_reg   = ra;
      req_pc    = a ^ 32'hC000_0000;
      if (push) exp_q.push_back({ex, ra, a ^ 32'hC000_0000, d});
   endtask

   task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                        input logic [1:0] mg, input logic [63:0] old, input logic [4:0] ra,
                        input logic push, input logic ex, input logic [63:0] d);
      int t = 0;
      set_req(a, sz, sg, mg, old, ra, push, ex, d);
      #1;
      while (!cur_req_ready && t < 50) begin @(posedge clk); #1; t++; end
      n_vec++;
      if (t >= 50) begin n_err++; $display("FAIL issue_timeout addr=%h ready=%b want=1", a, cur_req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic ram_pulse(input logic [63:0] d, input int lat);
      repeat (lat) begin @(posedge clk); #1; end
      ram_rvalid = 1'b1;
      ram_rdata  = d;
      @(posedge clk); #1;
      ram_rvalid = 1'b0;
   endtask

   task automatic take();
      int t = 0;
      logic [EW-1:0] got, exp;
      wb_ready = 1'b1;
      while (!cur_wb_valid && t < 50) begin @(posedge clk); #1; t++; end
      got = {cur_exc, cur_reg, cur_pc, cur_data};
      n_vec++;
      if (t >= 50) begin
         n_err++; $display("FAIL wb_timeout wb_valid=%b want=1", cur_wb_valid);
      end else if (exp_q.size() == 0) begin
         n_err++; $display("FAIL wb_unexpected got=%h want=none", got);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin n_err++; $display("FAIL wb_result got=%h want=%h", got, exp); end
      end
      @(posedge clk); #1;
      wb_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel64 = (s == 1);
         #1;
         n_vec++;
         if ({cur_wb_valid, cur_exc, cur_data, cur_reg, cur_pc} !== '0) begin
            n_err++; $display("FAIL reset_outputs dut64=%0d got v=%b e=%b d=%h r=%h pc=%h want all 0",
                              s, cur_wb_valid, cur_exc, cur_data, cur_reg, cur_pc);
         end
         n_vec++;
         if (cur_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", cur_req_ready); end
         n_vec++;
         if (cur_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d want=%0d", cur_state, IDLE); end
      end
      sel64 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_vec++;
      if (cur_req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got=%b want=1", cur_req_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_lane32();
      issue(32'h1003, SZ_BYTE, 1'b1, MG_NONE, 64'h0, 5'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80 & 64'hFFFF_FFFF);
      n_vec++;
      if (cur_wb_valid !== 1'b0 || cur_state !== WAIT) begin
         n_err++; $display("FAIL lb_wait got v=%b st=%0d want v=0 st=%0d", cur_wb_valid, cur_state, WAIT);
      end
      ram_pulse(64'h80FF_1234, 0);
      n_vec++;
      if (cur_wb_valid !== 1'b1) begin n_err++; $display("FAIL lb_latency got=%b want=1", cur_wb_valid); end
      take();

      issue(32'h1002, SZ_HALF, 1'b0, MG_NONE, 64'h0, 5'd2, 1'b1, 1'b0, 64'h0000_80FF);
      ram_pulse(64'h80FF_1234, 1);
      take();

      issue(32'h1001, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd3, 1'b1, 1'b1, 64'h0000_1001);
      n_vec++;
      if (cur_wb_valid !== 1'b1 || cur_exc !== 1'b1) begin
         n_err++; $display("FAIL lw_misaligned_latency got v=%b e=%b want v=1 e=1", cur_wb_valid, cur_exc);
      end
      take();

      issue(32'h1000, SZ_DWORD, 1'b0, MG_NONE, 64'h0, 5'd4, 1'b1, 1'b1, 64'h0000_1000);
      take();
   endtask

   task automatic test_merge();
      issue(32'h2001, SZ_WORD, 1'b0, MG_LWL, 64'h1122_3344, 5'd5, 1'b1, 1'b0, 64'hCCDD_3344);
      ram_pulse(64'hAABB_CCDD, 2);
      take();
      issue(32'h2001, SZ_WORD, 1'b0, MG_LWR, 64'h1122_3344, 5'd6, 1'b1, 1'b0, 64'h11AA_BBCC);
      ram_pulse(64'hAABB_CCDD, 0);
      take();
      // merge only applies to word size: a byte load with merge set is a plain byte load
      issue(32'h2002, SZ_BYTE, 1'b0, MG_LWL, 64'h1122_3344, 5'd7, 1'b1, 1'b0, 64'h0000_00BB);
      ram_pulse(64'hAABB_CCDD, 0);
      take();
   endtask

   task automatic test_back_to_back();
      logic [EW-1:0] exp;
      issue(32'h3000, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd7, 1'b1, 1'b0, 64'hDEAD_BEEF);
      ram_pulse(64'hDEAD_BEEF, 3);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (cur_wb_valid !== 1'b1 || cur_data !== 64'hDEAD_BEEF || cur_reg !== 5'd7 ||
             cur_pc !== (32'h3000 ^ 32'hC000_0000)) begin
            n_err++; $display("FAIL hold_stable cyc=%0d got v=%b d=%h r=%h pc=%h want v=1 d=deadbeef r=07",
                              i, cur_wb_valid, cur_data, cur_reg, cur_pc);
         end
         if (i < 2) begin @(posedge clk); #1; end
      end
      wb_ready = 1'b1;
      set_req(32'h3001, SZ_BYTE, 1'b0, MG_NONE, 64'h0, 5'd9, 1'b1, 1'b0, 64'h0000_0033);
      #1;
      n_vec++;
      if (cur_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b want=1", cur_req_ready); end
      n_vec++;
      exp = exp_q.pop_front();
      if ({cur_exc, cur_reg, cur_pc, cur_data} !== exp) begin
         n_err++; $display("FAIL b2b_first got=%h want=%h", {cur_exc, cur_reg, cur_pc, cur_data}, exp);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wb_ready  = 1'b0;
      n_vec++;
      if (cur_state !== WAIT || cur_wb_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_second_wait got st=%0d v=%b want st=%0d v=0", cur_state, cur_wb_valid, WAIT);
      end
      ram_pulse(64'h1122_3344, 0);
      take();
   endtask

   task automatic test_flush();
      issue(32'h4000, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd10, 1'b0, 1'b0, 64'h0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      n_vec++;
      if (cur_state !== DRAIN || cur_req_ready !== 1'b0 || cur_wb_valid !== 1'b0) begin
         n_err++; $display("FAIL flush_wait_drain got st=%0d rdy=%b v=%b want st=%0d rdy=0 v=0",
                           cur_state, cur_req_ready, cur_wb_valid, DRAIN);
      end
      @(posedge clk); #1;
      ram_pulse(64'h5555_5555, 0);
      n_vec++;
      if (cur_state !== IDLE || cur_req_ready !== 1'b1 || cur_wb_valid !== 1'b0) begin
         n_err++; $display("FAIL drain_done got st=%0d rdy=%b v=%b want st=%0d rdy=1 v=0",
                           cur_state, cur_req_ready, cur_wb_valid, IDLE);
      end

      issue(32'h4010, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd11, 1'b0, 1'b0, 64'h0);
      flush = 1'b1;
      ram_rvalid = 1'b1;
      ram_rdata = 64'h6666_6666;
      @(posedge clk); #1;
      flush = 1'b0;
      ram_rvalid = 1'b0;
      n_vec++;
      if (cur_state !== IDLE || cur_wb_valid !== 1'b0) begin
         n_err++; $display("FAIL flush_with_rvalid got st=%0d v=%b want st=%0d v=0", cur_state, cur_wb_valid, IDLE);
      end

      issue(32'h4002, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd12, 1'b0, 1'b0, 64'h0);
      n_vec++;
      if (cur_wb_valid !== 1'b1 || cur_exc !== 1'b1 || cur_data !== 64'h4002) begin
         n_err++; $display("FAIL done_before_flush got v=%b e=%b d=%h want v=1 e=1 d=4002",
                           cur_wb_valid, cur_exc, cur_data);
      end
      flush = 1'b1;
      set_req(32'h4100, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd13, 1'b0, 1'b0, 64'h0);
      wb_ready = 1'b1;
      #1;
      n_vec++;
      if (cur_req_ready !== 1'b0) begin n_err++; $display("FAIL flush_blocks_accept got=%b want=0", cur_req_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      req_valid = 1'b0;
      wb_ready = 1'b0;
      n_vec++;
      if (cur_wb_valid !== 1'b0 || cur_state !== IDLE) begin
         n_err++; $display("FAIL flush_done got v=%b st=%0d want v=0 st=%0d", cur_wb_valid, cur_state, IDLE);
      end
   endtask

   task automatic test_wide64();
      sel64 = 1'b1;
      #1;
      issue(32'h8, SZ_DWORD, 1'b0, MG_NONE, 64'h0, 5'd14, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
      ram_pulse(64'h0123_4567_89AB_CDEF, 1);
      take();
      issue(32'h4, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd15, 1'b1, 1'b0, 64'h0000_0000_89AB_CDEF);
      ram_pulse(64'h89AB_CDEF_0123_4567, 0);
      take();
      issue(32'h4, SZ_WORD, 1'b1, MG_NONE, 64'h0, 5'd16, 1'b1, 1'b0, 64'hFFFF_FFFF_89AB_CDEF);
      ram_pulse(64'h89AB_CDEF_0123_4567, 2);
      take();
      issue(32'h7, SZ_BYTE, 1'b1, MG_NONE, 64'h0, 5'd17, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF89);
      ram_pulse(64'h89AB_CDEF_0123_4567, 0);
      take();
      issue(32'h4, SZ_DWORD, 1'b0, MG_NONE, 64'h0, 5'd18, 1'b1, 1'b1, 64'h4);
      n_vec++;
      if (cur_wb_valid !== 1'b1) begin n_err++; $display("FAIL ld_misaligned_latency got=%b want=1", cur_wb_valid); end
      take();
      sel64 = 1'b0;
      #1;
   endtask

   function automatic logic [31:0] model32(input logic [31:0] rd, input int off, input int nb, input logic sg);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (sg && v[8*nb-1]) for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic test_random();
      logic [31:0] rd;
      logic [1:0]  sz;
      logic        sg;
      int          nb, off;
      for (int n = 0; n < 16; n++) begin
         sz  = 2'($urandom_range(0, 2));
         nb  = 1 << sz;
         off = int'($urandom_range(0, 4 / nb - 1)) * nb;
         sg  = 1'($urandom_range(0, 1));
         rd  = $urandom();
         issue(32'h6000 + 32'(n * 16 + off), sz, sg, MG_NONE, 64'h0, 5'(n), 1'b1, 1'b0,
               {32'h0, model32(rd, off, nb, sg)});
         ram_pulse({32'h0, rd}, int'($urandom_range(0, 3)));
         take();
      end
   endtask

   task automatic test_reset_mid_wait();
      issue(32'h5000, SZ_WORD, 1'b0, MG_NONE, 64'h0, 5'd3, 1'b0, 1'b0, 64'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if ({cur_wb_valid, cur_exc, cur_data, cur_reg, cur_pc} !== '0 || cur_state !== IDLE) begin
         n_err++; $display("FAIL reset_mid_wait got v=%b e=%b d=%h r=%h pc=%h st=%0d want 0 and IDLE",
                           cur_wb_valid, cur_exc, cur_data, cur_reg, cur_pc, cur_state);
      end
      n_vec++;
      if (cur_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_mid_wait_ready got=%b want=0", cur_req_ready); end
      rst = 1'b1;
      ram_pulse(64'h7777_7777, 0);
      n_vec++;
      if (cur_wb_valid !== 1'b0 || cur_state !== IDLE) begin
         n_err++; $display("FAIL rvalid_after_reset got v=%b st=%0d want v=0 st=%0d", cur_wb_valid, cur_state, IDLE);
      end
   endtask

   initial begin
      test_reset();
      test_lane32();
      test_merge();
      test_back_to_back();
      test_flush();
      test_wide64();
      test_random();
      test_reset_mid_wait();
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/wb_load_unit.md
# wb_load_unit

Parametrised, handshaked load-return unit for the writeback side of the pipeline. It takes a load request from MEM and waits a variable number of cycles for the RAM read response. It then extracts and extends the addressed lane, merges unaligned-word loads (LWL/LWR) with the old register value, and holds the result until the regfile side accepts it. Misaligned accesses raise an address-error flag; they are never silently zeroed. The unit also supports pipeline flush with in-flight response draining.

## Interface
Parameters:
- DATA_W, 32, RAM/register data width (32 or 64)
- ADDR_W, 32, address width
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  discard in-flight/held load
- req_valid / req_ready  in / out  1 / 1  MEM-side request handshake
- req_addr  in  ADDR_W  byte address
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword
- req_sign  in  1  sign-extend result
- req_merge  in  2  0 none, 1 LWL, 2 LWR (word size only, else treated as 0)
- req_old  in  DATA_W  current rt value for merge
- req_reg_addr  in  REG_ADDR_W  destination register
- req_pc  in  ADDR_W  debug PC
- ram_rvalid  in  1  read data valid pulse
- ram_rdata  in  DATA_W  aligned read word
- wb_valid / wb_ready  out / in  1 / 1  regfile-side handshake
- wb_data  out  DATA_W  formatted result, or faulting address on exception
- wb_reg_addr  out  REG_ADDR_W  destination register
- wb_pc  out  ADDR_W  debug PC
- wb_exc  out  1  address-error exception

## Operation
- FSM states: IDLE, WAIT, DRAIN, DONE.
- req_ready = rst & !flush & (IDLE | (DONE & wb_ready)). The accept condition is req_valid & req_ready. On accept, addr, size, sign, merge, old, reg_addr and pc are latched.
- Misalignment: an access is misaligned if req_addr[size-1:0] != 0, or if 2^size > DATA_W/8. On a misaligned accept the FSM goes to DONE directly with wb_exc=1 and wb_data = zero-extended req_addr. No RAM wait occurs.
- On an aligned accept the FSM goes to WAIT.
- In WAIT, a ram_rvalid pulse loads the formatted data into the output register, and the FSM goes to DONE.
- Lane extraction: off = addr[log2(DATA_W/8)-1:0]. The value is ram_rdata >> 8*off, truncated to 8·2^size bits, then sign-extended (req_sign) or zero-extended to DATA_W.
- Merge (32-bit word, k = addr[1:0]):
  - LWL = (rdata << 8(3−k)) | (old & (2^(8(3−k)) − 1))
  - LWR = (rdata >> 8k) | (old & ~(0xFFFFFFFF >> 8k))
  - Merge ignores the alignment check.
- DONE: wb_valid=1 and outputs are stable until wb_ready. On wb_ready the FSM goes to IDLE, or to the next state if a new request is accepted in the same cycle.
- Flush:
  - In DONE: the FSM goes to IDLE and wb_valid drops next cycle.
  - In WAIT: if ram_rvalid is not also high, the FSM goes to DRAIN. If ram_rvalid is high in the same cycle, the FSM goes to IDLE.
  - In DRAIN: ram_rvalid is discarded and the FSM goes to IDLE.
  - In IDLE: no effect.
- ram_rvalid in IDLE, or in DONE, is ignored.

## Timing
- Reset (rst=0 at an edge): state IDLE; wb_valid, wb_exc, wb_data, wb_reg_addr and wb_pc all 0. req_ready=0 while rst=0.
- Aligned load: accept at edge N. With ram_rvalid in cycle N+L (L≥0 cycles after WAIT entry), wb_valid is high from edge N+L+1.
- Misaligned load: wb_valid is high one cycle after accept.
- Output registers only; no combinational path from ram_rdata to wb_data.
- Back-to-back: accepting a new request in DONE with wb_ready gives zero bubble on the request side.
- Flush has priority over accept and over ram_rvalid capture.

## Structure
- Package wb_load_pkg:
  - size encodings (SZ_BYTE..SZ_DWORD)
  - merge encodings (MG_NONE/LWL/LWR)
  - FSM state enum
- Sub-module load_formatter: combinational extract, extend, merge and misalignment detect. It is shared by the capture path in WAIT and by the exception path at accept.

## Test plan
- LB at 0x1003, sign=1, rdata 0x80FF1234 -> wb_data 0xFFFFFF80, wb_exc 0.
- LHU at 0x1002, rdata 0x80FF1234 -> wb_data 0x000080FF. LW at 0x1001 -> wb_exc 1, wb_data 0x00001001, one cycle after accept.
- LWL k=1, rdata 0xAABBCCDD, old 0x11223344 -> 0xCCDD3344. LWR k=1 -> 0x11AABBCC.
- Aligned LW, ram_rvalid after 3 cycles, wb_ready low 2 cycles -> wb_* stable while held. New request accepted on the wb_ready edge, with no bubble.
- Flush in WAIT, ram_rvalid 2 cycles later -> no wb_valid, FSM in DRAIN then IDLE, req_ready high the cycle after the drained pulse.
- DATA_W=64: LD at 0x8 -> full rdata. LW at 0x4 -> rdata[63:32] extended. LD at 0x4 -> wb_exc 1.
- rst low for one cycle mid-WAIT -> all outputs 0, state IDLE, a later ram_rvalid is ignored.
